// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with any depth, a registered read port and fill-level flags.
// Define FIFO_SYNC_ERR_STICKY_EN to add sticky overflow/underflow flags.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] din,
`ifdef FIFO_SYNC_ERR_STICKY_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  rd_acc, wr_acc;

  // Flags decode the registered count only.
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CNT_W'(DEPTH));
  assign almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));
  assign almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
  assign fill_count   = cnt_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;

  // Accept logic, pointer wrap, count update and read-port load.
  always_comb begin
    rd_acc       = read_enable && !empty;
    wr_acc       = write_enable && (!full || rd_acc);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d     = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO and clears the read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is never cleared; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef FIFO_SYNC_ERR_STICKY_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_enable && !wr_acc) ovf_d = 1'b1;
    if (read_enable && empty)    unf_d = 1'b1;
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: DEPTH=16 and DEPTH=5 instances share stimulus,
// each checked against its own queue-style model.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, re, err_clr;
  logic [7:0] din;

  logic [7:0] dout_a, dout_b;
  logic       val_a, emp_a, full_a, ae_a, af_a;
  logic       val_b, emp_b, full_b, ae_b, af_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;
  logic       ovf_a, unf_a, ovf_b, unf_b;

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst),
    .write_enable(we), .read_enable(re), .din(din),
`ifdef FIFO_SYNC_ERR_STICKY_EN
    .err_clr(err_clr), .overflow(ovf_a), .underflow(unf_a),
`endif
    .dout(dout_a), .dout_valid(val_a),
    .empty(emp_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a),
    .fill_count(cnt_a)
  );

  fifo_sync_flags #(
    .DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .write_enable(we), .read_enable(re), .din(din),
`ifdef FIFO_SYNC_ERR_STICKY_EN
    .err_clr(err_clr), .overflow(ovf_b), .underflow(unf_b),
`endif
    .dout(dout_b), .dout_valid(val_b),
    .empty(emp_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b),
    .fill_count(cnt_b)
  );

`ifndef FIFO_SYNC_ERR_STICKY_EN
  assign ovf_a = 1'b0;
  assign unf_a = 1'b0;
  assign ovf_b = 1'b0;
  assign unf_b = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: every accepted push is logged in order; count = pushed - popped.
  int         dep [2] = '{16, 5};
  int         ael [2] = '{2, 1};
  int         afl [2] = '{14, 4};
  logic [7:0] hist [2][4096];
  int         npush [2];
  int         npop  [2];
  logic [7:0] e_dout [2];
  logic       e_val [2];
  logic       e_ovf [2];
  logic       e_unf [2];

  task automatic model(int k);
    int  cnt;
    bit  rd, wr;
    cnt = npush[k] - npop[k];
    if (rst) begin
      npush[k]  = 0;
      npop[k]   = 0;
      e_dout[k] = 8'h00;
      e_val[k]  = 1'b0;
      e_ovf[k]  = 1'b0;
      e_unf[k]  = 1'b0;
    end else begin
      rd = re && (cnt > 0);
      wr = we && ((cnt < dep[k]) || rd);
      if (err_clr) begin
        e_ovf[k] = 1'b0;
        e_unf[k] = 1'b0;
      end
      if (we && !wr)     e_ovf[k] = 1'b1;
      if (re && cnt == 0) e_unf[k] = 1'b1;
      e_val[k] = rd;
      if (rd) begin
        e_dout[k] = hist[k][npop[k] % 4096];
        npop[k]++;
      end
      if (wr) begin
        hist[k][npush[k] % 4096] = din;
        npush[k]++;
      end
    end
  endtask

  task automatic check_one(string n, int k, logic [7:0] d, logic v,
                           logic [31:0] c, logic e, logic f,
                           logic ae, logic af, logic ov, logic un);
    int cnt;
    cnt = npush[k] - npop[k];
    chk({n, "_valid"}, 32'(v), 32'(e_val[k]));
    chk({n, "_dout"}, 32'(d), 32'(e_dout[k]));
    chk({n, "_count"}, c, 32'(cnt));
    chk({n, "_empty"}, 32'(e), 32'(cnt == 0));
    chk({n, "_full"}, 32'(f), 32'(cnt == dep[k]));
    chk({n, "_aempty"}, 32'(ae), 32'(cnt <= ael[k]));
    chk({n, "_afull"}, 32'(af), 32'(cnt >= afl[k]));
`ifdef FIFO_SYNC_ERR_STICKY_EN
    chk({n, "_ovf"}, 32'(ov), 32'(e_ovf[k]));
    chk({n, "_unf"}, 32'(un), 32'(e_unf[k]));
`endif
  endtask

  task automatic cyc(logic r, logic w, logic rd, logic [7:0] d);
    rst = r;
    we  = w;
    re  = rd;
    din = d;
    @(posedge clk);
    model(0);
    model(1);
    @(negedge clk);
    check_one("a", 0, dout_a, val_a, 32'(cnt_a), emp_a, full_a,
              ae_a, af_a, ovf_a, unf_a);
    check_one("b", 1, dout_b, val_b, 32'(cnt_b), emp_b, full_b,
              ae_b, af_b, ovf_b, unf_b);
    err_clr = 1'b0;
  endtask

  initial begin
    int pw;
    rst = 1'b1; we = 1'b0; re = 1'b0; din = 8'h00; err_clr = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 8'h00);
    chk("rst_empty", 32'(emp_a), 32'd1);
    chk("rst_aempty", 32'(ae_a), 32'd1);

    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'(i));
    chk("fill_full", 32'(full_a), 32'd1);
    chk("fill_cnt", 32'(cnt_a), 32'd16);
    cyc(0, 1, 0, 8'hAA);
    chk("drop_cnt", 32'(cnt_a), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 8'h00);
      chk("pop_order", 32'(dout_a), 32'(i));
    end
    cyc(0, 0, 1, 8'h00);
    chk("drain_empty", 32'(emp_a), 32'd1);

    err_clr = 1'b1;
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 8'(8'h20 + i));
      chk("full_rw_cnt", 32'(cnt_a), 32'd16);
    end
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 8'h00);

    cyc(0, 1, 1, 8'h55);
    chk("no_bypass", 32'(val_a), 32'd0);
    chk("empty_rw_cnt", 32'(cnt_a), 32'd1);
    cyc(0, 0, 1, 8'h00);
    chk("empty_rw_data", 32'(dout_a), 32'h55);

    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 8'(8'h40 + i));
      cyc(0, 1, 1, 8'(8'h80 + i));
      cyc(0, 0, 1, 8'h00);
    end

    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(8'h60 + i));
    cyc(1, 0, 1, 8'h00);
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_dout", 32'(dout_a), 32'd0);
    chk("mid_rst_valid", 32'(val_a), 32'd0);
    cyc(0, 1, 0, 8'h3C);
    cyc(0, 0, 1, 8'h00);
    chk("post_rst_data", 32'(dout_a), 32'h3C);

    pw = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) pw = 20 + 30 * ((i / 250) % 3);
      err_clr = ($urandom % 32) == 0;
      cyc(($urandom % 64) == 0,
          ($urandom % 100) < pw,
          ($urandom % 100) < (100 - pw),
          8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
